button_conditioner: RTL
=======================

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter DB_CYCLES, default 500000, SHALL set the debounce qualification length in clock cycles (10 ms at 50 MHz); legal range 2..2^24.
REQ-002 Port clk, input, 1 bit: single system clock; all state SHALL update on its rising edge only.
REQ-003 Port rst, input, 1 bit: synchronous active-high reset, sampled on the rising edge of clk.
REQ-004 Port key_decrement, input, 1 bit: raw, asynchronous, bouncing decrement pushbutton, active-low (0 = pressed).
REQ-005 Port key_reset, input, 1 bit: raw, asynchronous, bouncing reset pushbutton, active-low (0 = pressed).
REQ-006 Port btn_decrement, output, 1 bit: debounced decrement level, active-low, idle 1; drives the counter's negedge decrement input.
REQ-007 Port btn_reset, output, 1 bit: debounced reset level, active-high, idle 0; drives the counter's posedge reset input.
REQ-008 Port dec_pulse, output, 1 bit: one-cycle strobe on each accepted decrement press.
REQ-009 Port rst_pulse, output, 1 bit: one-cycle strobe on each accepted reset press.

Function
REQ-010 Each key SHALL pass through its own 2-flip-flop synchronizer before any other logic; synchronizer flops SHALL reset to 1 (released).
REQ-011 Each channel SHALL have an independent FSM with states IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT and a counter of ceil(log2(DB_CYCLES)) bits.
REQ-012 IDLE: synchronized key = 0 -> PRESS_WAIT, counter cleared to 0; otherwise stay.
REQ-013 PRESS_WAIT: synchronized key = 1 -> IDLE (bounce rejected, no output change); key = 0 and counter < DB_CYCLES-1 -> counter +1; key = 0 and counter = DB_CYCLES-1 -> PRESSED.
REQ-014 PRESSED: synchronized key = 1 -> RELEASE_WAIT, counter cleared; otherwise stay, with no repeat strobes.
REQ-015 RELEASE_WAIT: synchronized key = 0 -> PRESSED (release bounce rejected); key = 1 and counter = DB_CYCLES-1 -> IDLE; otherwise counter +1.
REQ-016 The level output SHALL be asserted while the FSM is in PRESSED or RELEASE_WAIT and deasserted in IDLE or PRESS_WAIT; all outputs SHALL be registered.
REQ-017 The strobe SHALL be high for exactly the one cycle following the PRESS_WAIT -> PRESSED transition, never at any other time.
REQ-018 Latency: with edge k the first clk edge sampling a stable raw 0, the level SHALL assert and the strobe SHALL be high in the cycle after edge k+DB_CYCLES+2.
REQ-019 Release latency: with edge r the first edge sampling a stable raw 1, the level SHALL deassert in the cycle after edge r+DB_CYCLES+2.
REQ-020 Any raw pulse or gap shorter than DB_CYCLES cycles SHALL produce no change on the outputs.
REQ-021 The counter SHALL never wrap; it saturates at DB_CYCLES-1 for the single qualifying cycle.
REQ-022 Simultaneous events: both channels SHALL run independently; dec_pulse SHALL be suppressed (and btn_decrement held at 1) while btn_reset is asserted, giving reset priority.
REQ-023 A decrement press still qualifying when btn_reset deasserts SHALL complete normally; a press already accepted during reset SHALL NOT be strobed late.

Reset
REQ-024 On rst = 1 at a clk edge: both FSMs -> IDLE, counters 0, synchronizers 1, btn_decrement = 1, btn_reset = 0, dec_pulse = 0, rst_pulse = 0, effective the following cycle.
REQ-025 Reset mid-operation (any state) SHALL abort that operation with no strobe; a key still held after rst deasserts SHALL be re-qualified from IDLE and strobe once.

Verification (DB_CYCLES = 4)
REQ-026 Clean key_decrement press held 20 cycles -> btn_decrement low and dec_pulse high exactly once, in the cycle after edge k+6; btn_decrement returns to 1 six cycles after release.
REQ-027 key_decrement bouncing 0/1 every 2 cycles for 16 cycles, then released -> no change on any output.
REQ-028 Release bounce of 1-cycle glitches while held -> btn_decrement stays 0, no second dec_pulse.
REQ-029 key_reset and key_decrement pressed on the same edge -> rst_pulse once, btn_reset = 1, dec_pulse = 0, btn_decrement = 1.
REQ-030 rst asserted during PRESS_WAIT with key still held -> all outputs at reset values next cycle; after rst deasserts, exactly one dec_pulse, 6 cycles later.

Source files
------------

// File: rtl/button_conditioner.sv
// Two-channel pushbutton conditioner: each raw key is synchronized, debounced by a
// four-state qualifier, and turned into a registered level plus a one-cycle strobe.

module button_conditioner_channel #(
  parameter int unsigned DB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_keyRaw,
  output logic o_levelNext,
  output logic o_accept
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  logic [1:0]    r_sync;
  state_t        r_state;
  state_t        w_stateNext;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_countNext;
  logic          w_keySync;

  assign w_keySync = r_sync[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync  <= 2'b11;
      r_state <= IDLE;
      r_count <= '0;
    end else begin
      r_sync  <= {r_sync[0], i_keyRaw};
      r_state <= w_stateNext;
      r_count <= w_countNext;
    end
  end

  // The counter only advances while the key disagrees with the debounced level.
  always_comb begin
    w_stateNext = r_state;
    w_countNext = r_count;
    o_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_keySync) begin
          w_stateNext = PRESS_WAIT;
          w_countNext = '0;
        end
      end
      PRESS_WAIT: begin
        if (w_keySync) begin
          w_stateNext = IDLE;
        end else if (r_count == LAST) begin
          w_stateNext = PRESSED;
          o_accept    = 1'b1;
        end else begin
          w_countNext = r_count + 1'b1;
        end
      end
      PRESSED: begin
        if (w_keySync) begin
          w_stateNext = RELEASE_WAIT;
          w_countNext = '0;
        end
      end
      RELEASE_WAIT: begin
        if (!w_keySync) begin
          w_stateNext = PRESSED;
        end else if (r_count == LAST) begin
          w_stateNext = IDLE;
        end else begin
          w_countNext = r_count + 1'b1;
        end
      end
      default: begin
        w_stateNext = IDLE;
        w_countNext = '0;
      end
    endcase
  end

  assign o_levelNext = (w_stateNext == PRESSED) || (w_stateNext == RELEASE_WAIT);

endmodule

module button_conditioner #(
  parameter int unsigned DB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_decrement,
  input  logic key_reset,
  output logic btn_decrement,
  output logic btn_reset,
  output logic dec_pulse,
  output logic rst_pulse
);

  logic w_decLevelNext;
  logic w_decAccept;
  logic w_rstLevelNext;
  logic w_rstAccept;

  button_conditioner_channel #(.DB_CYCLES(DB_CYCLES)) u_decChannel (
    .clk         (clk),
    .rst         (rst),
    .i_keyRaw    (key_decrement),
    .o_levelNext (w_decLevelNext),
    .o_accept    (w_decAccept)
  );

  button_conditioner_channel #(.DB_CYCLES(DB_CYCLES)) u_rstChannel (
    .clk         (clk),
    .rst         (rst),
    .i_keyRaw    (key_reset),
    .o_levelNext (w_rstLevelNext),
    .o_accept    (w_rstAccept)
  );

  // Reset masks the decrement outputs in the same cycle it is visible, so a
  // decrement accepted while reset is held is dropped rather than strobed later.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_decrement <= 1'b1;
      btn_reset     <= 1'b0;
      dec_pulse     <= 1'b0;
      rst_pulse     <= 1'b0;
    end else begin
      btn_decrement <= ~(w_decLevelNext & ~w_rstLevelNext);
      btn_reset     <= w_rstLevelNext;
      dec_pulse     <= w_decAccept & ~w_rstLevelNext;
      rst_pulse     <= w_rstAccept;
    end
  end

endmodule
